// File: rtl/line_clear_sched_pkg.sv
// -----------------------------------------------------------------------------
// line_clear_sched_pkg
// Shared definitions for the line-clear scheduler slice:
//   - default board geometry (COLS, ROWS, RW)
//   - engine FSM state encoding
//   - score lookup for the number of rows cleared in one operation
// -----------------------------------------------------------------------------
package line_clear_sched_pkg;

    localparam int unsigned COLS_DEF = 10;   // board width in cells
    localparam int unsigned ROWS_DEF = 20;   // board height in rows
    localparam int unsigned RW_DEF   = 5;    // row address width
    localparam int unsigned PTS_W    = 11;   // score increment width
    localparam int unsigned CNT_W    = 3;    // cleared-row counter width
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD    = 4'd1,   // read row src
        ST_CHK   = 4'd2,   // inspect read data
        ST_WR    = 4'd3,   // write held word to row dst
        ST_ZF    = 4'd4,   // zero-fill rows dst..0
        ST_SCORE = 4'd5,   // one-cycle result pulse
        ST_FRD   = 4'd6,   // flash pre-pass read
        ST_FCHK  = 4'd7,   // flash pre-pass inspect
        ST_FWAIT = 4'd8    // flash: count vblank frames
    } state_t;

    // Classic score table indexed by rows cleared (saturated at 4).
    function automatic logic [PTS_W-1:0] score_of(input logic [CNT_W-1:0] n);
        logic [PTS_W-1:0] pts;
        case (n)
            3'd1:    pts = 11'd40;
            3'd2:    pts = 11'd100;
            3'd3:    pts = 11'd300;
            3'd4:    pts = 11'd1200;
            default: pts = 11'd0;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/line_clear_sched_board_arbiter.sv
// -----------------------------------------------------------------------------
// board_arbiter
// Fixed-priority three-way mux for the single board RAM port:
//   renderer (read) > lock writer (write) > clear engine (read or write).
// The engine only gets a slot while vblnk is high and neither external
// requester is active.
// Ports:
//   pclk, rst               clock / synchronous active-high reset
//   vblnk                   vertical blank, gates engine access
//   rnd_req/rnd_row         renderer read request and row
//   lck_req/lck_row/lck_wdata  lock-writer write request, row, data
//   eng_req/eng_we/eng_addr/eng_wdata  engine access request
//   rnd_gnt, lck_gnt        combinational grants
//   slot                    engine owns the port this cycle
//   ram_addr/ram_we/ram_wdata  board RAM port
//   eng_rd_vld              registered: ram_rdata now holds the engine's read
// -----------------------------------------------------------------------------
module board_arbiter
    import line_clear_sched_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned RW   = RW_DEF
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            vblnk,
    input  logic            rnd_req,
    input  logic [RW-1:0]   rnd_row,
    input  logic            lck_req,
    input  logic [RW-1:0]   lck_row,
    input  logic [COLS-1:0] lck_wdata,
    input  logic            eng_req,
    input  logic            eng_we,
    input  logic [RW-1:0]   eng_addr,
    input  logic [COLS-1:0] eng_wdata,
    output logic            rnd_gnt,
    output logic            lck_gnt,
    output logic            slot,
    output logic [RW-1:0]   ram_addr,
    output logic            ram_we,
    output logic [COLS-1:0] ram_wdata,
    output logic            eng_rd_vld
);

    logic eng_rd_vld_reg;

    assign rnd_gnt    = rnd_req;
    assign lck_gnt    = lck_req & ~rnd_req;
    assign slot       = vblnk & ~rnd_req & ~lck_req;
    assign eng_rd_vld = eng_rd_vld_reg;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rnd_req) begin
            ram_addr = rnd_row;
        end else if (lck_req) begin
            ram_addr  = lck_row;
            ram_we    = 1'b1;
            ram_wdata = lck_wdata;
        end else if (slot && eng_req) begin
            ram_addr  = eng_addr;
            ram_we    = eng_we;
            ram_wdata = eng_wdata;
        end
    end

    // RAM has one cycle of read latency: flag the cycle in which the engine's
    // data is on ram_rdata, whoever drives the address in that cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            eng_rd_vld_reg <= 1'b0;
        end else begin
            eng_rd_vld_reg <= slot & eng_req & ~eng_we;
        end
    end

endmodule

// File: rtl/line_clear_sched.sv
// -----------------------------------------------------------------------------
// line_clear_sched
// Line-clear sequencer for the board RAM (one COLS-bit word per row).
// On lock_en it scans rows bottom-up, compacts non-full rows downward,
// zero-fills the vacated top rows and reports a score increment. The RAM port
// is shared through board_arbiter (renderer > lock writer > engine).
//
// Optional feature macro: CLEAR_FLASH_EN
//   defined   : read-only pre-pass builds flash_rows; full rows flash for
//               FLASH_FRM vblank rising edges before compaction. An empty
//               mask goes straight to SCORE with zero.
//   undefined : single-pass compaction, flash_rows tied to 0.
//
// Ports:
//   pclk, rst          clock / synchronous active-high reset
//   vblnk              engine may only use RAM while high
//   lock_en            1-cycle start pulse (queued once if busy)
//   rnd_req/rnd_row/rnd_gnt             renderer read port
//   lck_req/lck_row/lck_wdata/lck_gnt   lock-writer write port
//   ram_addr/ram_we/ram_wdata/ram_rdata board RAM (1-cycle read latency)
//   busy               engine not idle
//   points_add/points_vld/lines         result of the last operation
//   flash_rows         mask of full rows currently flashing
// -----------------------------------------------------------------------------
module line_clear_sched
    import line_clear_sched_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned RW   = RW_DEF
`ifdef CLEAR_FLASH_EN
    ,
    parameter int unsigned FLASH_FRM = 8
`endif
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             lock_en,
    input  logic             rnd_req,
    input  logic [RW-1:0]    rnd_row,
    output logic             rnd_gnt,
    input  logic             lck_req,
    input  logic [RW-1:0]    lck_row,
    input  logic [COLS-1:0]  lck_wdata,
    output logic             lck_gnt,
    output logic [RW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [COLS-1:0]  ram_wdata,
    input  logic [COLS-1:0]  ram_rdata,
    output logic             busy,
    output logic [PTS_W-1:0] points_add,
    output logic             points_vld,
    output logic [CNT_W-1:0] lines,
    output logic [ROWS-1:0]  flash_rows
);

    localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);

    state_t             state_reg;
    logic [RW-1:0]      src_reg;
    logic [RW-1:0]      dst_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               pend_reg;
    logic [COLS-1:0]    word_reg;
    logic               points_vld_reg;
    logic [PTS_W-1:0]   points_add_reg;
    logic [CNT_W-1:0]   lines_reg;

    logic               eng_req;
    logic               eng_we;
    logic [RW-1:0]      eng_addr;
    logic [COLS-1:0]    eng_wdata;
    logic               slot;
    logic               eng_rd_vld;
    logic               row_full;

`ifdef CLEAR_FLASH_EN
    localparam int unsigned FRM_W = (FLASH_FRM < 2) ? 1 : $clog2(FLASH_FRM);
    localparam logic [FRM_W-1:0] FRM_LAST = (FLASH_FRM < 2) ? '0 : FRM_W'(FLASH_FRM - 1);

    logic [ROWS-1:0]    mask_reg;
    logic [FRM_W-1:0]   frm_reg;
    logic               vblnk_d_reg;
`endif

    assign row_full   = &ram_rdata;
    assign busy       = (state_reg != ST_IDLE);
    assign points_vld = points_vld_reg;
    assign points_add = points_add_reg;
    assign lines      = lines_reg;

`ifdef CLEAR_FLASH_EN
    assign flash_rows = (state_reg == ST_FWAIT) ? mask_reg : '0;
`else
    assign flash_rows = '0;
`endif

    // Engine port request, derived from the current state only.
    always_comb begin
        eng_req   = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        case (state_reg)
            ST_RD: begin
                eng_req  = 1'b1;
                eng_addr = src_reg;
            end
            ST_WR: begin
                eng_req   = 1'b1;
                eng_we    = 1'b1;
                eng_addr  = dst_reg;
                eng_wdata = word_reg;
            end
            ST_ZF: begin
                eng_req  = 1'b1;
                eng_we   = 1'b1;
                eng_addr = dst_reg;
            end
`ifdef CLEAR_FLASH_EN
            ST_FRD: begin
                eng_req  = 1'b1;
                eng_addr = src_reg;
            end
`endif
            default: ;
        endcase
    end

    board_arbiter #(
        .COLS(COLS),
        .RW  (RW)
    ) u_arb (
        .pclk      (pclk),
        .rst       (rst),
        .vblnk     (vblnk),
        .rnd_req   (rnd_req),
        .rnd_row   (rnd_row),
        .lck_req   (lck_req),
        .lck_row   (lck_row),
        .lck_wdata (lck_wdata),
        .eng_req   (eng_req),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .rnd_gnt   (rnd_gnt),
        .lck_gnt   (lck_gnt),
        .slot      (slot),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .eng_rd_vld(eng_rd_vld)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            cnt_reg        <= '0;
            pend_reg       <= 1'b0;
            word_reg       <= '0;
            points_vld_reg <= 1'b0;
            points_add_reg <= '0;
            lines_reg      <= '0;
`ifdef CLEAR_FLASH_EN
            mask_reg       <= '0;
            frm_reg        <= '0;
            vblnk_d_reg    <= 1'b0;
`endif
        end else begin
            points_vld_reg <= 1'b0;
`ifdef CLEAR_FLASH_EN
            vblnk_d_reg    <= vblnk;
`endif
            // One start request may queue while an operation is in flight,
            // including the SCORE cycle.
            if (lock_en && (state_reg != ST_IDLE)) begin
                pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (lock_en || pend_reg) begin
                        src_reg  <= ROW_TOP;
                        dst_reg  <= ROW_TOP;
                        cnt_reg  <= '0;
                        pend_reg <= 1'b0;
`ifdef CLEAR_FLASH_EN
                        mask_reg  <= '0;
                        state_reg <= ST_FRD;
`else
                        state_reg <= ST_RD;
`endif
                    end
                end

                ST_RD: begin
                    if (slot) begin
                        state_reg <= ST_CHK;
                    end
                end

                // Needs no port slot: data must be taken the cycle after the read.
                ST_CHK: begin
                    if (eng_rd_vld) begin
                        word_reg <= ram_rdata;
                        if (row_full) begin
                            if (cnt_reg != CNT_MAX) begin
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                            if (src_reg == '0) begin
                                state_reg <= ST_ZF;
                            end else begin
                                src_reg   <= src_reg - 1'b1;
                                state_reg <= ST_RD;
                            end
                        end else if (src_reg != dst_reg) begin
                            state_reg <= ST_WR;
                        end else if (src_reg == '0) begin
                            // Nothing moved and nothing vacated: no zero-fill.
                            points_vld_reg <= 1'b1;
                            points_add_reg <= score_of(cnt_reg);
                            lines_reg      <= cnt_reg;
                            state_reg      <= ST_SCORE;
                        end else begin
                            src_reg   <= src_reg - 1'b1;
                            dst_reg   <= dst_reg - 1'b1;
                            state_reg <= ST_RD;
                        end
                    end
                end

                ST_WR: begin
                    if (slot) begin
                        dst_reg <= dst_reg - 1'b1;
                        if (src_reg == '0) begin
                            // dst > src here, so dst-1 is still a valid row.
                            state_reg <= ST_ZF;
                        end else begin
                            src_reg   <= src_reg - 1'b1;
                            state_reg <= ST_RD;
                        end
                    end
                end

                ST_ZF: begin
                    if (slot) begin
                        if (dst_reg == '0) begin
                            points_vld_reg <= 1'b1;
                            points_add_reg <= score_of(cnt_reg);
                            lines_reg      <= cnt_reg;
                            state_reg      <= ST_SCORE;
                        end else begin
                            dst_reg <= dst_reg - 1'b1;
                        end
                    end
                end

                ST_SCORE: begin
                    state_reg <= ST_IDLE;
                end

`ifdef CLEAR_FLASH_EN
                ST_FRD: begin
                    if (slot) begin
                        state_reg <= ST_FCHK;
                    end
                end

                ST_FCHK: begin
                    if (eng_rd_vld) begin
                        if (row_full) begin
                            mask_reg[src_reg] <= 1'b1;
                        end
                        if (src_reg != '0) begin
                            src_reg   <= src_reg - 1'b1;
                            state_reg <= ST_FRD;
                        end else if ((mask_reg != '0) || row_full) begin
                            frm_reg   <= '0;
                            state_reg <= ST_FWAIT;
                        end else begin
                            points_vld_reg <= 1'b1;
                            points_add_reg <= score_of(cnt_reg);
                            lines_reg      <= cnt_reg;
                            state_reg      <= ST_SCORE;
                        end
                    end
                end

                ST_FWAIT: begin
                    if (vblnk && !vblnk_d_reg) begin
                        if (frm_reg == FRM_LAST) begin
                            mask_reg  <= '0;
                            src_reg   <= ROW_TOP;
                            dst_reg   <= ROW_TOP;
                            cnt_reg   <= '0;
                            state_reg <= ST_RD;
                        end else begin
                            frm_reg <= frm_reg + 1'b1;
                        end
                    end
                end
`endif

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_sched.sv
// Self-checking bench for line_clear_sched (default build, flashing disabled).
// A behavioural RAM holds the board; a reference model computes the cleared
// board and score directly from the board contents.
module tb_line_clear_sched;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int RW   = 5;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic            vblnk = 1'b0;
    logic            lock_en = 1'b0;
    logic            rnd_req = 1'b0;
    logic [RW-1:0]   rnd_row = '0;
    logic            rnd_gnt;
    logic            lck_req = 1'b0;
    logic [RW-1:0]   lck_row = '0;
    logic [COLS-1:0] lck_wdata = '0;
    logic            lck_gnt;
    logic [RW-1:0]   ram_addr;
    logic            ram_we;
    logic [COLS-1:0] ram_wdata;
    logic [COLS-1:0] ram_rdata;
    logic            busy;
    logic [10:0]     points_add;
    logic            points_vld;
    logic [2:0]      lines;
    logic [ROWS-1:0] flash_rows;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_viol = 0;

    logic [COLS-1:0] mem    [ROWS];
    logic [COLS-1:0] init_b [ROWS];
    logic [COLS-1:0] gold_b [ROWS];
    int              gold_cnt;
    logic [10:0]     gold_pts;

    always #5 pclk = ~pclk;

    line_clear_sched #(.COLS(COLS), .ROWS(ROWS), .RW(RW)) dut (
        .pclk(pclk), .rst(rst), .vblnk(vblnk), .lock_en(lock_en),
        .rnd_req(rnd_req), .rnd_row(rnd_row), .rnd_gnt(rnd_gnt),
        .lck_req(lck_req), .lck_row(lck_row), .lck_wdata(lck_wdata), .lck_gnt(lck_gnt),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .points_add(points_add), .points_vld(points_vld),
        .lines(lines), .flash_rows(flash_rows)
    );

    // Board RAM: synchronous write, registered read.
    always @(posedge pclk) begin
        if (ram_addr < RW'(ROWS)) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end else begin
            ram_rdata <= '0;
        end
    end

    // Reference: keep non-full rows in order, stack them at the bottom.
    task automatic compute_gold();
        int k;
        int full;
        k = ROWS - 1;
        full = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (init_b[r] == {COLS{1'b1}}) full++;
            else begin
                gold_b[k] = init_b[r];
                k--;
            end
        end
        for (int r = k; r >= 0; r--) gold_b[r] = '0;
        gold_cnt = (full > 4) ? 4 : full;
        case (gold_cnt)
            0: gold_pts = 11'd0;
            1: gold_pts = 11'd40;
            2: gold_pts = 11'd100;
            3: gold_pts = 11'd300;
            default: gold_pts = 11'd1200;
        endcase
    endtask

    function automatic int board_diff();
        int d = 0;
        for (int r = 0; r < ROWS; r++) if (mem[r] !== gold_b[r]) d++;
        return d;
    endfunction

    task automatic rand_board(input int pfull);
        logic [COLS-1:0] v;
        int p;
        for (int r = 0; r < ROWS; r++) begin
            p = $urandom_range(0, 99);
            if (p < pfull) init_b[r] = {COLS{1'b1}};
            else if (p < pfull + 15) init_b[r] = '0;
            else begin
                v = COLS'($urandom);
                v[$urandom_range(0, COLS - 1)] = 1'b0;
                init_b[r] = v;
            end
        end
    endtask

    // Load init_b through the lock-writer port.
    task automatic load_board();
        for (int r = 0; r < ROWS; r++) begin
            @(negedge pclk);
            lck_req = 1'b1;
            lck_row = RW'(r);
            lck_wdata = init_b[r];
        end
        @(negedge pclk);
        lck_req = 1'b0;
    endtask

    task automatic pulse_lock();
        @(negedge pclk);
        lock_en = 1'b1;
        @(negedge pclk);
        lock_en = 1'b0;
    endtask

    // mode 0: vblnk high; 1: random vblnk; 2: 1000-cycle vblank gap at cycle 20
    task automatic wait_done(input int mode, output bit seen,
                             output logic [10:0] pa, output logic [2:0] ln);
        seen = 1'b0;
        pa = '0;
        ln = '0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge pclk);
            if (ram_we && !vblnk && !lck_req && !rnd_req) wr_viol++;
            if (points_vld) begin
                seen = 1'b1;
                pa = points_add;
                ln = lines;
            end else begin
                case (mode)
                    1: vblnk = ($urandom_range(0, 3) != 0);
                    2: vblnk = !(c >= 20 && c < 1020);
                    default: vblnk = 1'b1;
                endcase
            end
        end
        vblnk = 1'b1;
        @(negedge pclk);
    endtask

    task automatic run_and_check(input string tag, input int mode);
        bit seen;
        logic [10:0] pa;
        logic [2:0] ln;
        int d;
        compute_gold();
        load_board();
        pulse_lock();
        wait_done(mode, seen, pa, ln);
        d = board_diff();
        n_tests++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL %s done: got %0d expected 1", tag, seen); end
        n_tests++;
        if (pa !== gold_pts) begin n_fail++; $display("FAIL %s points: got %0d expected %0d", tag, pa, gold_pts); end
        n_tests++;
        if (ln !== 3'(gold_cnt)) begin n_fail++; $display("FAIL %s lines: got %0d expected %0d", tag, ln, gold_cnt); end
        n_tests++;
        if (d !== 0) begin n_fail++; $display("FAIL %s board: got %0d bad rows expected 0", tag, d); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle: got busy=%0d expected 0", tag, busy); end
        $display("[TB] %s: points=%0d lines=%0d", tag, pa, ln);
    endtask

    task automatic test_reset();
        @(negedge pclk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %0d expected 0", busy); end
        n_tests++;
        if (points_vld !== 1'b0) begin n_fail++; $display("FAIL reset points_vld: got %0d expected 0", points_vld); end
        n_tests++;
        if (points_add !== 11'd0) begin n_fail++; $display("FAIL reset points_add: got %0d expected 0", points_add); end
        n_tests++;
        if (lines !== 3'd0) begin n_fail++; $display("FAIL reset lines: got %0d expected 0", lines); end
        n_tests++;
        if (flash_rows !== '0) begin n_fail++; $display("FAIL reset flash_rows: got %h expected 0", flash_rows); end
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset ram port: got we=%0d addr=%0d wdata=%h expected 0", ram_we, ram_addr, ram_wdata);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_port_grants();
        @(negedge pclk);
        lck_req = 1'b1; lck_row = 5'd5; lck_wdata = 10'h2A5; #1;
        n_tests++;
        if ({lck_gnt, rnd_gnt, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, 1'b1, 5'd5, 10'h2A5}) begin
            n_fail++;
            $display("FAIL lck grant: got gnt=%0d we=%0d addr=%0d wd=%h expected 1 1 5 2a5", lck_gnt, ram_we, ram_addr, ram_wdata);
        end
        rnd_req = 1'b1; rnd_row = 5'd12; #1;
        n_tests++;
        if ({lck_gnt, rnd_gnt, ram_we, ram_addr} !== {1'b0, 1'b1, 1'b0, 5'd12}) begin
            n_fail++;
            $display("FAIL rnd priority: got lgnt=%0d rgnt=%0d we=%0d addr=%0d expected 0 1 0 12", lck_gnt, rnd_gnt, ram_we, ram_addr);
        end
        @(negedge pclk);
        rnd_req = 1'b0; lck_req = 1'b0;
        $display("[TB] port grants checked");
    endtask

    task automatic test_single_row();
        for (int r = 0; r < ROWS; r++) init_b[r] = '0;
        for (int r = 0; r < 19; r++) init_b[r] = (r % 3 == 0) ? 10'h155 : '0;
        init_b[19] = 10'h3FF;
        run_and_check("single_row", 0);
        n_tests++;
        if (mem[0] !== 10'h000) begin n_fail++; $display("FAIL single_row top: got %h expected 000", mem[0]); end
    endtask

    task automatic test_four_rows();
        rand_board(0);
        for (int r = 16; r < 20; r++) init_b[r] = 10'h3FF;
        init_b[15] = 10'h1F0;
        run_and_check("four_rows", 0);
        n_tests++;
        if (mem[19] !== 10'h1F0) begin n_fail++; $display("FAIL four_rows row19: got %h expected 1f0", mem[19]); end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 10; i++) begin
            rand_board(20 + 5 * (i % 3));
            run_and_check($sformatf("random_%0d", i), i % 2);
        end
    endtask

    task automatic test_rnd_stall();
        bit seen;
        logic [10:0] pa;
        logic [2:0] ln;
        int bad = 0;
        rand_board(0);
        init_b[10] = 10'h3FF;
        compute_gold();
        load_board();
        vblnk = 1'b1;
        pulse_lock();
        repeat (8) @(negedge pclk);
        for (int c = 0; c < 50; c++) begin
            rnd_req = 1'b1;
            rnd_row = RW'($urandom_range(0, ROWS - 1));
            lck_req = ($urandom_range(0, 3) == 0);
            lck_row = RW'($urandom_range(0, ROWS - 1));
            #1;
            if (!rnd_gnt || lck_gnt || ram_we || ram_addr !== rnd_row || !busy) bad++;
            @(negedge pclk);
        end
        rnd_req = 1'b0;
        lck_req = 1'b0;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL stall port: got %0d bad cycles expected 0", bad); end
        wait_done(0, seen, pa, ln);
        n_tests++;
        if (seen !== 1'b1 || pa !== gold_pts || ln !== 3'(gold_cnt)) begin
            n_fail++;
            $display("FAIL stall result: got seen=%0d pts=%0d lines=%0d expected 1 %0d %0d", seen, pa, ln, gold_pts, gold_cnt);
        end
        n_tests++;
        if (board_diff() !== 0) begin n_fail++; $display("FAIL stall board: got %0d bad rows expected 0", board_diff()); end
        $display("[TB] rnd_stall: points=%0d lines=%0d", pa, ln);
    endtask

    task automatic test_vblank_pause();
        wr_viol = 0;
        rand_board(25);
        run_and_check("vblank_pause", 2);
        n_tests++;
        if (wr_viol !== 0) begin n_fail++; $display("FAIL vblank writes: got %0d expected 0", wr_viol); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [10:0] pa1 = '0, pa2 = '1;
        logic [2:0] ln2 = '1;
        rand_board(30);
        init_b[0] = 10'h3FF;
        compute_gold();
        load_board();
        vblnk = 1'b1;
        pulse_lock();
        repeat (5) @(negedge pclk);
        pulse_lock();
        for (int c = 0; c < 600; c++) begin
            @(negedge pclk);
            if (points_vld) begin
                pulses++;
                if (pulses == 1) pa1 = points_add;
                if (pulses == 2) begin pa2 = points_add; ln2 = lines; end
            end
        end
        n_tests++;
        if (pulses !== 2) begin n_fail++; $display("FAIL b2b pulses: got %0d expected 2", pulses); end
        n_tests++;
        if (pa1 !== gold_pts) begin n_fail++; $display("FAIL b2b first points: got %0d expected %0d", pa1, gold_pts); end
        // The queued operation sees the already compacted board.
        n_tests++;
        if (pa2 !== 11'd0 || ln2 !== 3'd0) begin n_fail++; $display("FAIL b2b second: got pts=%0d lines=%0d expected 0 0", pa2, ln2); end
        n_tests++;
        if (board_diff() !== 0) begin n_fail++; $display("FAIL b2b board: got %0d bad rows expected 0", board_diff()); end
        $display("[TB] back_to_back: pulses=%0d first=%0d second=%0d", pulses, pa1, pa2);
    endtask

    task automatic test_lock_in_score();
        int pulses = 0;
        bit hit = 1'b0;
        rand_board(20);
        compute_gold();
        load_board();
        vblnk = 1'b1;
        pulse_lock();
        for (int c = 0; c < 600; c++) begin
            @(negedge pclk);
            lock_en = 1'b0;
            if (points_vld) begin
                pulses++;
                if (!hit) begin hit = 1'b1; lock_en = 1'b1; end
            end
        end
        n_tests++;
        if (pulses !== 2) begin n_fail++; $display("FAIL score-cycle lock: got %0d pulses expected 2", pulses); end
        $display("[TB] lock_in_score: pulses=%0d", pulses);
    endtask

    task automatic test_reset_mid_zf();
        bit found = 1'b0;
        for (int r = 0; r < 16; r++) init_b[r] = RW'(r) == 0 ? 10'h001 : COLS'(r * 37) & 10'h1FF;
        for (int r = 16; r < 20; r++) init_b[r] = 10'h3FF;
        load_board();
        vblnk = 1'b1;
        pulse_lock();
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge pclk);
            if (ram_we && ram_addr == 5'd3 && !lck_req && !rnd_req) found = 1'b1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL mid_zf reach: got 0 expected 1"); end
        rst = 1'b1;
        @(negedge pclk);
        n_tests++;
        if (busy !== 1'b0 || points_vld !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_zf reset: got busy=%0d vld=%0d we=%0d expected 0 0 0", busy, points_vld, ram_we);
        end
        rst = 1'b0;
        @(negedge pclk);
        // Finish the job from whatever the board now holds.
        for (int r = 0; r < ROWS; r++) init_b[r] = mem[r];
        run_and_check("after_reset", 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        vblnk = 1'b1;
        test_reset();
        test_port_grants();
        test_single_row();
        test_four_rows();
        test_random_ops();
        test_rnd_stall();
        test_vblank_pause();
        test_back_to_back();
        test_lock_in_score();
        test_reset_mid_zf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
